// File: rtl/crm_diag_seq_pkg.sv
// crm_diag_seq_pkg: shared ebox types and diag function codes for the CRAM load sequencer
// Contents: tCRADR address type, sequencer state enum, step-index enum,
//           diag function code constants, per-step function/data helpers.
package crm_diag_seq_pkg;

    typedef logic [0:10] tCRADR;

    typedef enum logic [1:0] {ST_IDLE, ST_STEP, ST_DONE} state_t;

    typedef enum logic [2:0] {IX_ADRLO, IX_ADRHI, IX_W00, IX_W20, IX_W40, IX_W60} step_t;

    localparam logic [2:0] FN_ADRLO = 3'd1;
    localparam logic [2:0] FN_ADRHI = 3'd2;
    localparam logic [2:0] FN_W00   = 3'd7;
    localparam logic [2:0] FN_W20   = 3'd6;
    localparam logic [2:0] FN_W40   = 3'd5;
    localparam logic [2:0] FN_W60   = 3'd4;

    function automatic logic [2:0] step_func(step_t s);
        return s == IX_ADRLO ? FN_ADRLO :
               s == IX_ADRHI ? FN_ADRHI :
               s == IX_W00   ? FN_W00   :
               s == IX_W20   ? FN_W20   :
               s == IX_W40   ? FN_W40   : FN_W60;
    endfunction

    // 20-bit microword slice carried by a word step (address steps fall through to W60)
    function automatic logic [0:19] word_slice(logic [0:79] w, step_t s);
        return s == IX_W00 ? w[0:19]  :
               s == IX_W20 ? w[20:39] :
               s == IX_W40 ? w[40:59] : w[60:79];
    endfunction

    function automatic logic [0:35] step_data(tCRADR a, logic [0:79] w, step_t s);
        return s == IX_ADRLO ? {a[5:10], 30'b0} :
               s == IX_ADRHI ? {1'b0, a[0:4], 30'b0} :
                               {word_slice(w, s), 16'b0};
    endfunction

endpackage

// File: rtl/crm_diag_step_timer.sv
// diag_step_timer: setup / strobe / hold phase counter for one diagnostic step
// Ports: clk, RESET (sync, active-high), run (count while a step is active),
//        stepSetup (setup cycle of the step), stepLast (last hold cycle of the step).
module diag_step_timer #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic RESET,
    input  logic run,
    output logic stepSetup,
    output logic stepLast
);

    // 0 = setup, 1 = strobe, 2..HOLD_CYCLES+1 = hold
    logic [4:0] cnt;

    assign stepSetup = run && cnt == 5'd0;
    assign stepLast  = run && cnt == 5'(HOLD_CYCLES + 1);

    always_ff @(posedge clk) begin
        if (RESET || !run)
            cnt <= '0;
        else
            cnt <= stepLast ? '0 : cnt + 5'd1;
    end

endmodule

// File: rtl/crm_diag_seq.sv
// crm_diag_seq: loads one 80-bit CRAM microword through the diagnostic EBUS path
// Ports: clk, RESET (sync, active-high), start, adr[0:10], word[0:79] in;
//        busy, done, diagFunc[4:6], loadFunc05x, ebusDrive, ebusData[0:35] out.
// Option CRM_DIAG_VERIFY_EN: adds readFunc, ebusIn[0:35], mismatch and four
//        read-back steps after W60 that compare ebusIn[0:19] with the written slices.
module crm_diag_seq
    import crm_diag_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        start,
    input  logic [0:10] adr,
    input  logic [0:79] word,
    output logic        busy,
    output logic        done,
    output logic [4:6]  diagFunc,
    output logic        loadFunc05x,
    output logic        ebusDrive,
    output logic [0:35] ebusData
`ifdef CRM_DIAG_VERIFY_EN
    ,
    output logic        readFunc,
    input  logic [0:35] ebusIn,
    output logic        mismatch
`endif
);

    state_t      state;
    step_t       idx;
    step_t       nidx;
    tCRADR       adr_q;
    logic [0:79] word_q;
    logic        run;
    logic        step_setup;
    logic        step_last;
    logic        final_step;
`ifdef CRM_DIAG_VERIFY_EN
    logic        rd;
    logic        nrd;
`endif

    assign run = state == ST_STEP;

    diag_step_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
        .clk      (clk),
        .RESET    (RESET),
        .run      (run),
        .stepSetup(step_setup),
        .stepLast (step_last)
    );

    // Read-back reuses the W00..W60 indices with rd set, so the index stays 3 bits
    always_comb begin
`ifdef CRM_DIAG_VERIFY_EN
        final_step = rd && idx == IX_W60;
        nrd        = rd || idx == IX_W60;
        nidx       = idx == IX_W60 ? IX_W00 : step_t'(idx + 3'd1);
`else
        final_step = idx == IX_W60;
        nidx       = step_t'(idx + 3'd1);
`endif
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state       <= ST_IDLE;
            idx         <= IX_ADRLO;
            adr_q       <= '0;
            word_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            diagFunc    <= '0;
            loadFunc05x <= 1'b0;
            ebusDrive   <= 1'b0;
            ebusData    <= '0;
`ifdef CRM_DIAG_VERIFY_EN
            rd          <= 1'b0;
            readFunc    <= 1'b0;
            mismatch    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    state     <= ST_STEP;
                    idx       <= IX_ADRLO;
                    adr_q     <= adr;
                    word_q    <= word;
                    busy      <= 1'b1;
                    diagFunc  <= FN_ADRLO;
                    ebusDrive <= 1'b1;
                    ebusData  <= step_data(adr, word, IX_ADRLO);
`ifdef CRM_DIAG_VERIFY_EN
                    rd        <= 1'b0;
                    mismatch  <= 1'b0;
`endif
                end
                ST_STEP: begin
`ifdef CRM_DIAG_VERIFY_EN
                    loadFunc05x <= step_setup && !rd;
                    readFunc    <= step_setup && rd;
                    if (step_last && rd && ebusIn[0:19] != word_slice(word_q, idx))
                        mismatch <= 1'b1;
`else
                    loadFunc05x <= step_setup;
`endif
                    if (step_last && final_step) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        diagFunc  <= '0;
                        ebusDrive <= 1'b0;
                        ebusData  <= '0;
                    end else if (step_last) begin
                        idx       <= nidx;
                        diagFunc  <= step_func(nidx);
`ifdef CRM_DIAG_VERIFY_EN
                        rd        <= nrd;
                        ebusDrive <= !nrd;
                        ebusData  <= nrd ? '0 : step_data(adr_q, word_q, nidx);
`else
                        ebusDrive <= 1'b1;
                        ebusData  <= step_data(adr_q, word_q, nidx);
`endif
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crm_diag_seq.sv
// tb_crm_diag_seq: randomized self-checking bench for crm_diag_seq (HOLD_CYCLES 1 and 3)
module tb_crm_diag_seq;

`ifdef CRM_DIAG_VERIFY_EN
    localparam int NSTEPS = 10;
`else
    localparam int NSTEPS = 6;
`endif

    logic        clk = 1'b0;
    logic        RESET;
    logic        start1, start3;
    logic [10:0] adr;
    logic [79:0] word;
    logic        busy1, done1, lf1, drv1;
    logic        busy3, done3, lf3, drv3;
    logic [2:0]  fn1, fn3;
    logic [35:0] dat1, dat3;
    logic        rf1, rf3;
`ifdef CRM_DIAG_VERIFY_EN
    logic        mm1, mm3;
    logic [35:0] ein;
`else
    assign rf1 = 1'b0;
    assign rf3 = 1'b0;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    crm_diag_seq #(.HOLD_CYCLES(1)) dut (
        .clk(clk), .RESET(RESET), .start(start1), .adr(adr), .word(word),
        .busy(busy1), .done(done1), .diagFunc(fn1), .loadFunc05x(lf1),
        .ebusDrive(drv1), .ebusData(dat1)
`ifdef CRM_DIAG_VERIFY_EN
        , .readFunc(rf1), .ebusIn(ein), .mismatch(mm1)
`endif
    );

    crm_diag_seq #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .RESET(RESET), .start(start3), .adr(adr), .word(word),
        .busy(busy3), .done(done3), .diagFunc(fn3), .loadFunc05x(lf3),
        .ebusDrive(drv3), .ebusData(dat3)
`ifdef CRM_DIAG_VERIFY_EN
        , .readFunc(rf3), .ebusIn(ein), .mismatch(mm3)
`endif
    );

    // Step s: 0 ADRLO, 1 ADRHI, 2..5 W00..W60, 6..9 R00..R60
    function automatic logic [2:0] code(int s);
        int tbl[6] = '{1, 2, 7, 6, 5, 4};
        return 3'(tbl[s >= 6 ? s - 4 : s]);
    endfunction

    function automatic logic [35:0] wdata(int s);
        if (s == 0) return {adr[5:0], 30'b0};
        if (s == 1) return {1'b0, adr[10:6], 30'b0};
        return {20'(word >> (20 * (5 - s))), 16'b0};
    endfunction

    // Expected {busy,done,drive,load,read,func,data} in cycle k after the accepting edge
    function automatic logic [43:0] model(int h, int k);
        int   len = 2 + h;
        int   s   = (k - 1) / len;
        int   p   = (k - 1) % len;
        logic w;
        if (k > NSTEPS * len) return {2'b01, 42'b0};
        w = s < 6;
        return {1'b1, 1'b0, w, w && p == 1, !w && p == 1, code(s), w ? wdata(s) : 36'b0};
    endfunction

    function automatic logic [43:0] obs(int h);
        return h == 3 ? {busy3, done3, drv3, lf3, rf3, fn3, dat3}
                      : {busy1, done1, drv1, lf1, rf1, fn1, dat1};
    endfunction

`ifdef CRM_DIAG_VERIFY_EN
    // Echo of the written slice during read steps; corrupt flips bit 7 of R40
    function automatic logic [35:0] ein_model(int h, int k, bit corrupt);
        int s = (k - 1) / (2 + h);
        logic [35:0] v;
        if (s < 6 || s > 9) return 36'b0;
        v = wdata(s - 4);
        if (corrupt && s == 8) v ^= 36'h1 << 28;
        return v;
    endfunction
`endif

    task automatic kick(input int h);
        @(negedge clk);
        if (h == 3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
    endtask

    task automatic test_load(input int h, input bit corrupt);
        int T = NSTEPS * (2 + h);
        logic [43:0] got, exp;
        kick(h);
        for (int k = 1; k <= T + 1; k++) begin
            @(negedge clk);
`ifdef CRM_DIAG_VERIFY_EN
            ein = ein_model(h, k, corrupt);
`endif
            got = obs(h);
            exp = model(h, k);
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL load h=%0d k=%0d got=%h exp=%h", h, k, got, exp);
            end
`ifdef CRM_DIAG_VERIFY_EN
            if (k == T + 1) begin
                checks++;
                if ((h == 3 ? mm3 : mm1) !== corrupt) begin
                    fails++;
                    $display("FAIL mismatch_at_done h=%0d got=%b exp=%b", h, h == 3 ? mm3 : mm1, corrupt);
                end
            end
`endif
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (obs(1) !== 44'b0) begin fails++; $display("FAIL reset_h1 got=%h exp=0", obs(1)); end
        if (obs(3) !== 44'b0) begin fails++; $display("FAIL reset_h3 got=%h exp=0", obs(3)); end
`ifdef CRM_DIAG_VERIFY_EN
        checks++;
        if ({mm1, mm3} !== 2'b00) begin fails++; $display("FAIL reset_mismatch got=%b exp=00", {mm1, mm3}); end
`endif
        RESET = 1'b0;
    endtask

    task automatic test_basic();
        adr  = 11'h5A3;
        word = 80'hFFFFF_00000_ABCDE_12345;
        test_load(1, 1'b0);
    endtask

    task automatic test_hold3();
        adr  = 11'h5A3;
        word = 80'hFFFFF_00000_ABCDE_12345;
        test_load(3, 1'b0);
    endtask

    task automatic test_random();
        repeat (4) begin
            adr  = 11'($urandom);
            word = 80'({$urandom, $urandom, $urandom});
            test_load(1, 1'b0);
            test_load(3, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int T = NSTEPS * 3;
        logic [43:0] got, exp;
        adr  = 11'($urandom);
        word = 80'({$urandom, $urandom, $urandom});
        @(negedge clk);
        start1 = 1'b1;
        for (int k = 1; k <= T + 1; k++) begin
            @(negedge clk);
`ifdef CRM_DIAG_VERIFY_EN
            ein = ein_model(1, k, 1'b0);
`endif
            got = obs(1);
            exp = model(1, k);
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL start_ignored k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (obs(1) !== 44'b0) begin fails++; $display("FAIL idle_after_done got=%h exp=0", obs(1)); end
        @(negedge clk);
        start1 = 1'b0;
        checks++;
        if (obs(1) !== model(1, 1)) begin fails++; $display("FAIL restart got=%h exp=%h", obs(1), model(1, 1)); end
        pulse_reset();
    endtask

    task automatic test_reset_mid();
        logic [43:0] got, exp;
        adr  = 11'($urandom);
        word = 80'({$urandom, $urandom, $urandom});
        kick(1);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            got = obs(1);
            exp = model(1, k);
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL pre_reset k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        RESET = 1'b1;
        @(negedge clk);
        checks++;
        if (obs(1) !== 44'b0) begin fails++; $display("FAIL reset_mid got=%h exp=0", obs(1)); end
        RESET = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if ({busy1, lf1, drv1} !== 3'b000) begin
                fails++;
                $display("FAIL after_reset k=%0d busy/load/drive=%b exp=000", k, {busy1, lf1, drv1});
            end
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        RESET  = 1'b1;
        start1 = 1'b1;
        start3 = 1'b1;
        @(posedge clk);
        #1;
        RESET  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if ({busy1, lf1, busy3, lf3} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_priority k=%0d busy/load=%b exp=0000", k, {busy1, lf1, busy3, lf3});
            end
        end
    endtask

`ifdef CRM_DIAG_VERIFY_EN
    task automatic test_verify();
        adr  = 11'h5A3;
        word = 80'hFFFFF_00000_ABCDE_12345;
        test_load(1, 1'b0);
        test_load(1, 1'b1);
        kick(1);
        @(negedge clk);
        checks++;
        if (mm1 !== 1'b0) begin fails++; $display("FAIL mismatch_clear got=%b exp=0", mm1); end
        pulse_reset();
    endtask
`endif

    initial begin
        RESET  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        adr    = '0;
        word   = '0;
`ifdef CRM_DIAG_VERIFY_EN
        ein    = '0;
`endif
        test_reset();
        test_basic();
        test_hold3();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_reset_priority();
`ifdef CRM_DIAG_VERIFY_EN
        test_verify();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/crm_diag_seq.md
CRM_DIAG_SEQ -- requirements
Module: crm_diag_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1 (range 1-15), giving the number of EBUS hold cycles after each strobe.
REQ-002 SHALL have port clk, input, 1 bit: the single clock (the CRA clock domain); all state changes on its posedge.
REQ-003 SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to load one CRAM word.
REQ-005 SHALL have port adr, input, 11 bits [0:10]: target CRAM address (tCRADR).
REQ-006 SHALL have port word, input, 80 bits [0:79]: microword to write.
REQ-007 SHALL have port busy, output, 1 bit: sequence in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port diagFunc, output, 3 bits [4:6]: diagnostic function select (drives CTL DIAG[4:6]).
REQ-010 SHALL have port loadFunc05x, output, 1 bit: one-cycle diagnostic load strobe for the 05x function group.
REQ-011 SHALL have port ebusDrive, output, 1 bit: this block owns EBUS.
REQ-012 SHALL have port ebusData, output, 36 bits [0:35]: EBUS data driven.

Function
REQ-013 Accept start only in IDLE; start while busy SHALL be ignored; adr/word captured on the accepting edge.
REQ-014 Steps SHALL be issued in this fixed order:
- ADRLO: func 1, ebusData[0:5]=adr[5:10]
- ADRHI: func 2, ebusData[1:5]=adr[0:4]
- W00: func 7, ebusData[0:19]=word[0:19]
- W20: func 6, ebusData[0:19]=word[20:39]
- W40: func 5, ebusData[0:19]=word[40:59]
- W60: func 4, ebusData[0:19]=word[60:79]
Unused ebusData bits SHALL be 0.
REQ-015 Each step SHALL be 2+HOLD_CYCLES cycles:
- setup: ebusDrive=1, data and func valid, strobe 0
- strobe: loadFunc05x=1
- HOLD_CYCLES hold cycles: data and func held, strobe 0
REQ-016 States SHALL be IDLE, STEP (with a 3-bit step index and a hold counter), DONE; DONE SHALL last one cycle with done=1 and busy=0, then go to IDLE.
REQ-017 Timing from start accepted at edge N:
- busy=1 from cycle N+1;
- done=1 exactly at cycle N+1+6*(2+HOLD_CYCLES), which is cycle N+19 with the default.
REQ-018 The next start SHALL be accepted no earlier than the cycle after done.
REQ-019 In IDLE and DONE: ebusDrive=0, ebusData=0, diagFunc=0, loadFunc05x=0.
REQ-020 Adjacent steps SHALL be back-to-back, with ebusDrive continuously 1 between the first setup and the last hold.

Reset
REQ-021 RESET=1 SHALL return the block to IDLE at the next edge and force all outputs to 0, including mid-sequence; no further strobes SHALL be issued.
REQ-022 RESET and start asserted together: RESET SHALL win and start SHALL be dropped.

Configuration
REQ-023 Macro CRM_DIAG_VERIFY_EN defined SHALL add these ports:
- readFunc, output, 1 bit
- ebusIn, input, 36 bits [0:35]
- mismatch, output, 1 bit
REQ-024 With CRM_DIAG_VERIFY_EN, after W60 four read steps (R00, R20, R40, R60) SHALL follow:
- timing as in REQ-015, with readFunc=1 replacing loadFunc05x, ebusDrive=0, and diagFunc equal to the matching write code;
- ebusIn[0:19] sampled on the last hold cycle and compared with the corresponding word slice;
- done moves to N+1+10*(2+HOLD_CYCLES).
REQ-025 mismatch SHALL be sticky, cleared on start acceptance and on RESET, and valid when done=1.
REQ-026 Without CRM_DIAG_VERIFY_EN the verify ports, states and logic SHALL be absent and timing SHALL be per REQ-017.

Structure
REQ-027 The shared ebox package SHALL hold the state enum, the step-index enum, the diag function code constants (ADRLO=1, ADRHI=2, W00=7, W20=6, W40=5, W60=4) and reuse the existing tCRADR.
REQ-028 A single sub-module diag_step_timer SHALL implement the setup/strobe/hold counter and emit stepLast; all sequencing SHALL stay in crm_diag_seq.

Verification
REQ-029 Basic load: HOLD_CYCLES=1, start with adr=11'h5A3, word=80'hFFFFF_00000_ABCDE_12345 -> six strobes with func 1,2,7,6,5,4; ebusData[0:5]=6'h23 then ebusData[1:5]=5'h16; write data 20'hFFFFF, 20'h00000, 20'hABCDE, 20'h12345; done at N+19.
REQ-030 Start ignored: start re-asserted every cycle while busy -> exactly one sequence; next sequence begins after done.
REQ-031 Reset mid-sequence: RESET during W20 strobe cycle -> next cycle all outputs 0, state IDLE, W40/W60 never strobed.
REQ-032 Reset priority: RESET and start in the same cycle -> busy stays 0, no strobe for 10 cycles.
REQ-033 HOLD_CYCLES=3 -> each step 5 cycles; done at N+31; ebusData stable across each step.
REQ-034 CRM_DIAG_VERIFY_EN: ebusIn echoes the written slices -> mismatch=0, done at N+31; corrupt R40 bit 7 -> mismatch=1 at done; next start clears it.
